apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max ACCESS-phase cycles before abort; 0 disables timeout.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_strb  input  4  write byte strobes.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-013 rsp_err  output  1  transfer failed (slverr or timeout).
REQ-014 rsp_timeout  output  1  failure was a timeout.
REQ-015 apb  apb_if.master  -  drives addr, sel, enable, write, wdata, strb; samples ready, slverr, rdata.

Function
REQ-016 States IDLE, SETUP, ACCESS, RESP; one transfer outstanding at a time.
REQ-017 req_ready = 1 only in IDLE; IDLE with req_valid=1 -> register write/addr/wdata/strb, go to SETUP.
REQ-018 SETUP (exactly 1 cycle): sel=1, enable=0; then go to ACCESS.
REQ-019 ACCESS: sel=1, enable=1; stay until apb.ready=1 or timeout.
REQ-020 apb.addr, write, wdata, strb held constant from SETUP through the final ACCESS cycle; they keep their last value after.
REQ-021 Reads drive apb.strb=4'b0000 and wdata=0; writes drive req_strb unmodified.
REQ-022 ACCESS with apb.ready=1: read captures apb.rdata into rsp_rdata, write sets rsp_rdata=0; rsp_err=apb.slverr, rsp_timeout=0; go to RESP.
REQ-023 Wait counter clears on entering ACCESS and increments each ACCESS cycle with apb.ready=0.
REQ-024 Timeout when TIMEOUT_CYCLES!=0 and counter == TIMEOUT_CYCLES with apb.ready=0: rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
REQ-025 apb.ready=1 in the same cycle as the timeout condition is a normal completion (ready wins).
REQ-026 apb.sel and apb.enable are both 0 in RESP and IDLE; no back-to-back ACCESS without SETUP.
REQ-027 RESP: rsp_valid=1, response fields stable until rsp_ready=1; then go to IDLE, rsp_valid=0.
REQ-028 Minimum latency: accept at edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid high in cycle N+3 when ready=1 in first ACCESS cycle.
REQ-029 apb.rdata sampled only in a completing ACCESS cycle; X on apb.rdata elsewhere has no effect.
REQ-030 Counter width holds TIMEOUT_CYCLES without wrap.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE: sel=0, enable=0, write=0, addr=0, wdata=0, strb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-032 req_ready=1 during and after reset (IDLE).
REQ-033 Reset mid-transfer (SETUP/ACCESS/RESP) aborts with no response; sel drops in the same cycle.

Verification
REQ-034 Read addr 0x8 against the team's apb_slave after reset, rsp_ready=1 -> sel/enable sequence 10,11; rsp_rdata=0xFFFF0002, rsp_err=0, rsp_valid in cycle N+3.
REQ-035 Write 0xDEADBEEF to 0x4 with strb 4'hF, then read 0x4 -> rsp_rdata=0xDEADBEEF; read drives strb=0.
REQ-036 Slave holds ready=0 for 3 ACCESS cycles then ready=1, slverr=1 -> addr/wdata stable for all 4 ACCESS cycles; rsp_err=1, rsp_timeout=0.
REQ-037 TIMEOUT_CYCLES=4, slave never ready -> abort after 4 waits; rsp_err=1, rsp_timeout=1, rsp_rdata=0; sel=0 next cycle.
REQ-038 rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready=0, response stable, no new SETUP until rsp_ready=1.
REQ-039 rst_n pulsed low during ACCESS -> sel, enable, rsp_valid=0 immediately; next request completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// APB bus bundle: the master drives the address/control/data side, the slave answers.
interface apb_if;
    logic [31:0] addr;
    logic        sel;
    logic        enable;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        ready;
    logic        slverr;
    logic [31:0] rdata;

    modport master (
        output addr, sel, enable, write, wdata, strb,
        input  ready, slverr, rdata
    );

    modport slave (
        input  addr, sel, enable, write, wdata, strb,
        output ready, slverr, rdata
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: request/response handshakes on the user side,
// SETUP/ACCESS sequencing with an optional ACCESS-phase timeout on the bus side.
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    apb_if.master       apb
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_write;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic               r_timeout;
    logic               w_timeout;

    // A ready slave in the same cycle always wins over the timeout.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !apb.ready
                       && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        apb.sel     = 1'b0;
        apb.enable  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                apb.sel     = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                apb.sel    = 1'b1;
                apb.enable = 1'b1;
                if (apb.ready || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_wait_cnt <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_write ? req_wdata : '0;
                        r_strb  <= req_write ? req_strb  : '0;
                    end
                end
                S_SETUP: begin
                    r_wait_cnt <= '0;
                end
                S_ACCESS: begin
                    if (apb.ready) begin
                        r_rdata   <= r_write ? '0 : apb.rdata;
                        r_err     <= apb.slverr;
                        r_timeout <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign apb.addr    = r_addr;
    assign apb.write   = r_write;
    assign apb.wdata   = r_wdata;
    assign apb.strb    = r_strb;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign rsp_timeout = r_timeout;
endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master with a scripted wait-state slave.
module tb_apb_master;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    apb_if bus ();

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int unsigned waits;
        bit          err;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          tmo;
        int          cyc;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scripted slave: answers each transfer after the planned number of wait cycles.
    initial begin
        plan_t       cur;
        bit          have = 0;
        bit          prev_sel = 0;
        int unsigned acc = 0;
        int unsigned idx;
        cur = '{waits: 0, err: 0, write: 0, addr: '0, wdata: '0, strb: '0};
        bus.ready  = 1'b0;
        bus.slverr = 1'b0;
        bus.rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.sel && !bus.enable) begin
                chk("setup_follows_idle", {31'b0, prev_sel}, 32'd0);
                if (plan_q.size() == 0) begin
                    fail_event("setup_without_request");
                    have = 0;
                end else begin
                    cur  = plan_q.pop_front();
                    have = 1;
                end
                acc = 0;
                if (have) begin
                    chk("setup_addr", bus.addr, cur.addr);
                    chk("setup_write", {31'b0, bus.write}, {31'b0, cur.write});
                    chk("setup_wdata", bus.wdata, cur.wdata);
                    chk("setup_strb", {28'b0, bus.strb}, {28'b0, cur.strb});
                end
                bus.ready  = 1'($urandom);
                bus.slverr = 1'($urandom);
                bus.rdata  = $urandom;
            end else if (bus.sel && bus.enable) begin
                chk("access_follows_sel", {31'b0, prev_sel}, 32'd1);
                chk("access_len_within_timeout", (acc <= TO) ? 32'd1 : 32'd0, 32'd1);
                if (have) begin
                    chk("access_addr_stable", bus.addr, cur.addr);
                    chk("access_write_stable", {31'b0, bus.write}, {31'b0, cur.write});
                    chk("access_wdata_stable", bus.wdata, cur.wdata);
                    chk("access_strb_stable", {28'b0, bus.strb}, {28'b0, cur.strb});
                end
                idx = 32'(bus.addr[5:2]);
                if (acc == cur.waits) begin
                    bus.ready  = 1'b1;
                    bus.slverr = cur.err;
                    bus.rdata  = bus.write ? $urandom : slv_mem[idx];
                    if (bus.write && !cur.err) begin
                        for (int b = 0; b < 4; b++) begin
                            if (bus.strb[b]) slv_mem[idx][8*b +: 8] = bus.wdata[8*b +: 8];
                        end
                    end
                end else begin
                    bus.ready  = 1'b0;
                    bus.slverr = 1'($urandom);
                    bus.rdata  = $urandom;
                end
                acc++;
            end else begin
                chk("enable_without_sel", {31'b0, bus.enable}, 32'd0);
                bus.ready  = 1'($urandom);
                bus.slverr = 1'($urandom);
                bus.rdata  = $urandom;
            end
            prev_sel = bus.sel;
        end
    end

    // Response monitor: pops the scoreboard on each new response, checks holding otherwise.
    initial begin
        bit          pv = 0;
        bit          pr = 0;
        int          stall = 0;
        logic [31:0] hr = '0;
        bit          he = 0;
        bit          ht = 0;
        exp_t        e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (req_valid) chk("req_ready_low_in_resp", {31'b0, req_ready}, 32'd0);
                if (!pv || pr) begin
                    if (exp_q.size() == 0) begin
                        fail_event("unexpected_response");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.tmo});
                        chk("rsp_latency_cycle", 32'(cyc), 32'(e.cyc));
                    end
                    hr = rsp_rdata;
                    he = rsp_err;
                    ht = rsp_timeout;
                end else begin
                    chk("rsp_rdata_held", rsp_rdata, hr);
                    chk("rsp_err_held", {31'b0, rsp_err}, {31'b0, he});
                    chk("rsp_timeout_held", {31'b0, rsp_timeout}, {31'b0, ht});
                end
            end
            if (stall > 0) begin
                rsp_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 7) == 0) begin
                rsp_ready = 1'b0;
                stall = 4;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            pv = rsp_valid;
            pr = rsp_ready;
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int unsigned waits, input bit err,
                         input bit expect_rsp);
        int          guard = 0;
        plan_t       p;
        exp_t        e;
        int unsigned idx;
        bit          tmo;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            fail_event("request_not_accepted");
            req_valid = 1'b0;
            return;
        end
        p = '{waits: waits, err: err, write: wr, addr: addr,
              wdata: wr ? wdata : 32'd0, strb: wr ? strb : 4'd0};
        plan_q.push_back(p);
        if (!expect_rsp) return;
        idx = 32'(addr[5:2]);
        tmo = (TO != 0) && (waits > TO);
        if (tmo) begin
            e = '{rdata: 32'd0, err: 1'b1, tmo: 1'b1, cyc: cyc + 3 + int'(TO)};
        end else begin
            e = '{rdata: wr ? 32'd0 : ref_mem[idx], err: err, tmo: 1'b0, cyc: cyc + 3 + int'(waits)};
            if (wr && !err) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || !req_ready) && guard < 500) begin
            @(negedge clk);
            req_valid = 1'b0;
            guard++;
        end
        if (exp_q.size() != 0) fail_event("responses_missing_at_drain");
    endtask

    initial begin
        int gap;
        int guard;
        #400000;
        $display("FAIL watchdog_expired (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int guard;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 32'hFFFF_0000 + 32'(i);
            ref_mem[i] = 32'hFFFF_0000 + 32'(i);
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        #12;
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_sel", {31'b0, bus.sel}, 32'd0);
        chk("reset_enable", {31'b0, bus.enable}, 32'd0);
        chk("reset_write", {31'b0, bus.write}, 32'd0);
        chk("reset_addr", bus.addr, 32'd0);
        chk("reset_wdata", bus.wdata, 32'd0);
        chk("reset_strb", {28'b0, bus.strb}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("reset_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 32'h0000_0008, $urandom, 4'hA, 0, 1'b0, 1'b1);
        issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_0004, $urandom, 4'hF, 0, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_000C, $urandom, 4'h3, 3, 1'b1, 1'b1);
        issue(1'b1, 32'h0000_0010, $urandom, 4'b0101, 3, 1'b1, 1'b1);
        issue(1'b0, 32'h0000_0014, $urandom, 4'h0, 10, 1'b0, 1'b1);
        issue(1'b1, 32'h0000_0018, $urandom, 4'hF, 10, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_0018, $urandom, 4'h0, TO, 1'b0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom), $urandom & 32'hFFFF_FF3C, $urandom, 4'($urandom),
                  $urandom_range(0, 6), ($urandom_range(0, 3) == 0), 1'b1);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        drain();

        // Abort a read mid-ACCESS with an asynchronous reset; no response may follow.
        issue(1'b0, 32'h0000_0020, $urandom, 4'h0, 6, 1'b0, 1'b0);
        guard = 0;
        while (!(bus.sel && bus.enable) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!(bus.sel && bus.enable)) fail_event("access_not_reached_before_reset");
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_sel", {31'b0, bus.sel}, 32'd0);
        chk("midreset_enable", {31'b0, bus.enable}, 32'd0);
        chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midreset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midreset_addr", bus.addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        plan_q.delete();
        issue(1'b0, 32'h0000_0008, $urandom, 4'h0, 1, 1'b0, 1'b1);
        issue(1'b1, 32'h0000_0030, $urandom, 4'b1001, 0, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_0030, $urandom, 4'h0, 2, 1'b0, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
